idli_pc_ctl_m: RTL and testbench

- Sequences the nibble-serial program counter.
- Arbitrates between two requesters: sequential-advance (fetch) and branch redirect (execute).
- Converts each accepted request into a slice-aligned 4-cycle operation on the PC datapath: increment, or serial load of a 16-bit target LSB nibble first.
- Tracks the rotation phase so every operation starts on bits [3:0] and the PC's internal increment counter and carry stay aligned.

---
 rtl/idli_pc_ctl_m.sv | 112 +++++++++++
 tb/tb_idli_pc_ctl_m.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_pc_ctl_m.sv
// PC sequencing control: arbitrates fetch-increment and branch-redirect
// requests and turns each accepted one into a phase-aligned 4-cycle
// operation on the nibble-serial PC datapath.
module idli_pc_ctl_m #(
    parameter bit BR_OVER_INC = 1'b1
) (
    input  logic        i_pc_gck,
    input  logic        i_pc_rst_n,
    input  logic        i_ctl_stall,
    input  logic        i_ctl_inc_req,
    output logic        o_ctl_inc_ack,
    input  logic        i_ctl_br_req,
    input  logic [15:0] i_ctl_br_tgt,
    output logic        o_ctl_br_ack,
    output logic        o_pc_inc,
    output logic        o_pc_ld,
    output logic [3:0]  o_pc_ld_data,
    output logic [1:0]  o_ctl_phase,
    output logic        o_ctl_busy,
    output logic        o_ctl_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        LD   = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  phase_reg;
    logic [15:0] tgt_reg;
    logic        accept_ok;
    logic        inc_ack;
    logic        br_ack;

    // Phase follows the datapath rotation: one nibble per cycle, 0 = bits [3:0].
    always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
        if (!i_pc_rst_n) begin
            phase_reg <= 2'd0;
        end else begin
            phase_reg <= phase_reg + 2'd1;
        end
    end

    // Acceptance window and priority arbitration; the reset term keeps acks
    // low while the datapath is being held in reset.
    always_comb begin
        accept_ok = i_pc_rst_n && (state_reg == IDLE) && (phase_reg == 2'd0) && !i_ctl_stall;
        inc_ack   = accept_ok && i_ctl_inc_req && (!i_ctl_br_req || !BR_OVER_INC);
        br_ack    = accept_ok && i_ctl_br_req && (!i_ctl_inc_req || BR_OVER_INC);
    end

    // State register.
    always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
        if (!i_pc_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: an operation occupies exactly one full rotation.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (br_ack) begin
                    state_next = LD;
                end else if (inc_ack) begin
                    state_next = INC;
                end
            end
            INC, LD: begin
                if (phase_reg == 2'd3) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Target shift register: nibble 0 is bypassed from the input in the ack
    // cycle, so only the upper three nibbles are stored, pre-shifted.
    always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
        if (!i_pc_rst_n) begin
            tgt_reg <= 16'h0000;
        end else if (br_ack) begin
            tgt_reg <= {4'h0, i_ctl_br_tgt[15:4]};
        end else if (state_reg == LD) begin
            tgt_reg <= {4'h0, tgt_reg[15:4]};
        end
    end

    // Outputs: the accept cycle already drives the datapath for phase 0.
    always_comb begin
        o_ctl_inc_ack = inc_ack;
        o_ctl_br_ack  = br_ack;
        o_pc_inc      = inc_ack || (state_reg == INC);
        o_pc_ld       = br_ack || (state_reg == LD);
        o_pc_ld_data  = 4'h0;
        if (br_ack) begin
            o_pc_ld_data = i_ctl_br_tgt[3:0];
        end else if (state_reg == LD) begin
            o_pc_ld_data = tgt_reg[3:0];
        end
        o_ctl_phase   = phase_reg;
        o_ctl_busy    = inc_ack || br_ack || (state_reg != IDLE);
        o_ctl_done    = (state_reg != IDLE) && (phase_reg == 2'd3);
    end

endmodule

// File: tb/tb_idli_pc_ctl_m.sv
// Bench for idli_pc_ctl_m: unit 0 has branch priority, unit 1 increment
// priority. Expected acks are queued by the stimulus and matched by a
// per-cycle monitor, which also drives a small nibble-serial PC model.
module tb_idli_pc_ctl_m;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        inc_req_v [2];
    logic        br_req_v [2];
    logic [15:0] br_tgt;

    logic [1:0]      inc_ack_w;
    logic [1:0]      br_ack_w;
    logic [1:0]      pc_inc_w;
    logic [1:0]      pc_ld_w;
    logic [1:0][3:0] ld_data_w;
    logic [1:0][1:0] phase_w;
    logic [1:0]      busy_w;
    logic [1:0]      done_w;

    logic [31:0] cyc;
    int          n_checks;
    int          n_errors;

    typedef struct {
        int          unit;
        bit          br;
        logic [15:0] tgt;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int          op_left [2];
    bit          op_br [2];
    logic [15:0] op_tgt [2];
    int          op_idx [2];
    logic [15:0] pc_m [2];
    logic        carry_m [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        idli_pc_ctl_m #(.BR_OVER_INC(gi == 0 ? 1'b1 : 1'b0)) u_dut (
            .i_pc_gck      (clk),
            .i_pc_rst_n    (rst_n),
            .i_ctl_stall   (stall),
            .i_ctl_inc_req (inc_req_v[gi]),
            .o_ctl_inc_ack (inc_ack_w[gi]),
            .i_ctl_br_req  (br_req_v[gi]),
            .i_ctl_br_tgt  (br_tgt),
            .o_ctl_br_ack  (br_ack_w[gi]),
            .o_pc_inc      (pc_inc_w[gi]),
            .o_pc_ld       (pc_ld_w[gi]),
            .o_pc_ld_data  (ld_data_w[gi]),
            .o_ctl_phase   (phase_w[gi]),
            .o_ctl_busy    (busy_w[gi]),
            .o_ctl_done    (done_w[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since the last reset release; cycle k has phase k mod 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon_unit(input int u);
        exp_t        e;
        logic        ack;
        logic [3:0]  nib;
        logic [4:0]  sum;
        int          p;
        string       pfx;
        pfx = $sformatf("u%0d_", u);
        p   = int'(cyc[1:0]);
        check_val({pfx, "phase"}, 32'(phase_w[u]), 32'(cyc[1:0]));
        check_val({pfx, "mutex"}, 32'(pc_inc_w[u] & pc_ld_w[u]), 32'd0);
        ack = inc_ack_w[u] | br_ack_w[u];
        if (op_left[u] == 0) begin
            if (ack) begin
                if (exp_q.size() == 0) begin
                    check_val({pfx, "unexp_ack"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val({pfx, "ack_unit"}, 32'(u), 32'(e.unit));
                    check_val({pfx, "ack_kind"}, 32'(br_ack_w[u]), 32'(e.br));
                    check_val({pfx, "ack_cyc"}, cyc, 32'(e.cyc));
                    op_left[u] = 4;
                    op_br[u]   = e.br;
                    op_tgt[u]  = e.tgt;
                    op_idx[u]  = 0;
                end
            end else begin
                check_val({pfx, "idle_out"},
                          32'({busy_w[u], pc_inc_w[u], pc_ld_w[u], ld_data_w[u], done_w[u]}), 32'd0);
            end
        end else begin
            check_val({pfx, "ack_in_op"}, 32'(ack), 32'd0);
        end
        if (op_left[u] > 0) begin
            check_val({pfx, "op_inc"}, 32'(pc_inc_w[u]), 32'(!op_br[u]));
            check_val({pfx, "op_ld"}, 32'(pc_ld_w[u]), 32'(op_br[u]));
            check_val({pfx, "op_data"}, 32'(ld_data_w[u]),
                      op_br[u] ? 32'(op_tgt[u][op_idx[u]*4 +: 4]) : 32'd0);
            check_val({pfx, "op_done"}, 32'(done_w[u]), 32'(op_idx[u] == 3));
            check_val({pfx, "op_busy"}, 32'(busy_w[u]), 32'd1);
            op_idx[u]++;
            op_left[u]--;
        end
        // Datapath model: serial add of a carry-in of 1 starting at nibble 0.
        nib = pc_m[u][p*4 +: 4];
        if (pc_inc_w[u]) begin
            sum = {1'b0, nib} + {4'h0, carry_m[u]};
            nib = sum[3:0];
            carry_m[u] = sum[4];
        end else if (pc_ld_w[u]) begin
            nib = ld_data_w[u];
        end
        pc_m[u][p*4 +: 4] = nib;
        if (p == 3) carry_m[u] = 1'b1;
    endtask

    // Per-cycle monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                op_left[u] = 0;
                pc_m[u]    = 16'h0000;
                carry_m[u] = 1'b1;
            end
        end else begin
            for (int u = 0; u < 2; u++) mon_unit(u);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int c);
        while (int'(cyc) < c) tick();
    endtask

    task automatic push_exp(input int u, input bit br, input logic [15:0] tgt, input int c);
        exp_t e;
        e.unit = u;
        e.br   = br;
        e.tgt  = tgt;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Raise a request, hold it until acked (bounded), drop it next cycle.
    task automatic hold_req(input int u, input bit br, input logic [15:0] tgt);
        bit got;
        got = 1'b0;
        if (br) begin
            br_req_v[u] = 1'b1;
            br_tgt      = tgt;
        end else begin
            inc_req_v[u] = 1'b1;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = br ? br_ack_w[u] : inc_ack_w[u];
        end
        if (!got) check_val($sformatf("u%0d_ack_timeout", u), 32'd0, 32'd1);
        tick();
        if (br) br_req_v[u] = 1'b0;
        else    inc_req_v[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        br_tgt   = 16'h0000;
        for (int u = 0; u < 2; u++) begin
            inc_req_v[u] = 1'b0;
            br_req_v[u]  = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;

        // Increment held from cycle 0.
        push_exp(0, 1'b0, 16'h0, 0);
        hold_req(0, 1'b0, 16'h0);
        tick_until(4);
        check_val("pc_inc1", 32'(pc_m[0]), 32'h0001);

        // Request at phase 2 waits for phase 0, then a back-to-back increment.
        tick_until(6);
        push_exp(0, 1'b0, 16'h0, 8);
        push_exp(0, 1'b0, 16'h0, 12);
        hold_req(0, 1'b0, 16'h0);
        hold_req(0, 1'b0, 16'h0);
        tick_until(16);
        check_val("pc_b2b", 32'(pc_m[0]), 32'h0003);

        // Branch load, then increment with carry across nibbles.
        push_exp(0, 1'b1, 16'hBEEF, 16);
        hold_req(0, 1'b1, 16'hBEEF);
        tick_until(20);
        check_val("pc_ld_beef", 32'(pc_m[0]), 32'hBEEF);
        push_exp(0, 1'b0, 16'h0, 20);
        hold_req(0, 1'b0, 16'h0);
        tick_until(24);
        check_val("pc_carry", 32'(pc_m[0]), 32'hBEF0);

        // Simultaneous requests, branch priority.
        push_exp(0, 1'b1, 16'h1234, 24);
        push_exp(0, 1'b0, 16'h0, 28);
        fork
            hold_req(0, 1'b1, 16'h1234);
            hold_req(0, 1'b0, 16'h0);
        join
        tick_until(32);
        check_val("pc_br_prio", 32'(pc_m[0]), 32'h1235);

        // Simultaneous requests, increment priority.
        push_exp(1, 1'b0, 16'h0, 32);
        push_exp(1, 1'b1, 16'h1234, 36);
        fork
            hold_req(1, 1'b0, 16'h0);
            hold_req(1, 1'b1, 16'h1234);
        join
        tick_until(40);
        check_val("pc_inc_prio", 32'(pc_m[1]), 32'h1234);

        // Stall over two phase-0 cycles defers acceptance to cycle 48.
        push_exp(0, 1'b0, 16'h0, 48);
        fork
            begin
                stall = 1'b1;
                tick_until(45);
                stall = 1'b0;
            end
            hold_req(0, 1'b0, 16'h0);
        join
        // Stall during an in-flight increment must not cut it short.
        tick_until(50);
        stall = 1'b1;
        tick_until(52);
        stall = 1'b0;
        check_val("pc_stall", 32'(pc_m[0]), 32'h1236);

        // Reset in the middle of a branch to 0xFFFF.
        push_exp(0, 1'b1, 16'hFFFF, 52);
        hold_req(0, 1'b1, 16'hFFFF);
        tick_until(54);
        rst_n = 1'b0;
        inc_req_v[0] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_val($sformatf("u%0d_rst_out", u),
                      32'({inc_ack_w[u], br_ack_w[u], pc_inc_w[u], pc_ld_w[u],
                           ld_data_w[u], phase_w[u], busy_w[u], done_w[u]}), 32'd0);
        end
        tick();
        push_exp(0, 1'b0, 16'h0, 0);
        rst_n = 1'b1;
        hold_req(0, 1'b0, 16'h0);
        tick_until(4);
        check_val("pc_after_rst", 32'(pc_m[0]), 32'h0001);

        // Request withdrawn before reaching phase 0 has no effect.
        tick_until(5);
        inc_req_v[0] = 1'b1;
        tick();
        tick();
        inc_req_v[0] = 1'b0;
        tick_until(12);
        check_val("pc_withdraw", 32'(pc_m[0]), 32'h0001);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
